tank_level_counter: RTL and testbench

- Parametrised synchronous level counter for the pump system. Replaces the dual-edge, clock-less up/down counter with a single-clock design.
- Two sensor pulse streams, each prescaled by its own ratio, move a saturating level count: fill moves it up, drain moves it down and is counted only while the pump runs.
- A hysteresis FSM derives the pump request from programmable low/high thresholds.
- Sits between the sensor front-end and the pump driver / display logic.

---
 rtl/pump_pkg.sv | 21 ++
 rtl/pulse_prescaler.sv | 61 ++++++
 rtl/tank_level_counter.sv | 148 ++++++++++++++
 tb/tb_tank_level_counter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// Shared pump-system types and default constants, used by the level counter
// and the pump driver.
package pump_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      FILLING = 1'b1
   } pump_state_e;

   localparam int PUMP_WIDTH     = 8;
   localparam int PUMP_FILL_DIV  = 4;
   localparam int PUMP_DRAIN_DIV = 4;
   localparam int PUMP_LOW_THR   = 16;
   localparam int PUMP_HIGH_THR  = 240;

   // A divide-by-one counter still needs one bit of storage.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/pulse_prescaler.sv
// Synchronises one raw sensor pulse, detects its rising edge and emits a
// one-cycle step every DIV qualifying edges.
module pulse_prescaler
   import pump_pkg::*;
#(
   parameter int DIV = PUMP_FILL_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse_in,
   input  logic enable,
   output logic step
);

   localparam int              CW   = cnt_width(DIV);
   localparam logic [CW-1:0]   LAST = CW'(DIV - 1);
   localparam logic [CW-1:0]   ONE  = CW'(1);

   logic [1:0]    sync_q;
   logic          prev_q;
   logic          strobe_s;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          step_q;
   logic          step_d;

   // Divide counter; a strobe with enable low leaves the count untouched.
   always_comb begin
      cnt_d    = cnt_q;
      step_d   = 1'b0;
      strobe_s = sync_q[1] & ~prev_q;
      if (strobe_s && enable) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            step_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Synchroniser, edge history, count and step register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pulse_in};
         prev_q <= sync_q[1];
         cnt_q  <= cnt_d;
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/tank_level_counter.sv
// Saturating tank level counter with hysteresis pump request.
// Optional sticky saturation alarm: define TANK_ALARM_EN.
module tank_level_counter
   import pump_pkg::*;
#(
   parameter int WIDTH      = PUMP_WIDTH,
   parameter int FILL_DIV   = PUMP_FILL_DIV,
   parameter int DRAIN_DIV  = PUMP_DRAIN_DIV,
   parameter int INIT_LEVEL = (2 ** WIDTH) - 1,
   parameter int LOW_THR    = PUMP_LOW_THR,
   parameter int HIGH_THR   = PUMP_HIGH_THR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill_pulse,
   input  logic             drain_pulse,
   input  logic             pump_on,
`ifdef TANK_ALARM_EN
   input  logic             alarm_clr,
   output logic             alarm,
`endif
   output logic [WIDTH-1:0] level,
   output logic             empty,
   output logic             full,
   output logic             pump_req
);

   localparam logic [WIDTH-1:0] LVL_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] LVL_MIN  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] LVL_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] LVL_INIT = WIDTH'(INIT_LEVEL);
   localparam logic [WIDTH-1:0] LVL_LOW  = WIDTH'(LOW_THR);
   localparam logic [WIDTH-1:0] LVL_HIGH = WIDTH'(HIGH_THR);

   logic             up_step_s;
   logic             dn_step_s;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] level_d;
   pump_state_e      state_q;
   pump_state_e      state_d;

   pulse_prescaler #(.DIV(FILL_DIV)) u_fill (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (fill_pulse),
      .enable   (1'b1),
      .step     (up_step_s)
   );

   pulse_prescaler #(.DIV(DRAIN_DIV)) u_drain (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (drain_pulse),
      .enable   (pump_on),
      .step     (dn_step_s)
   );

   // Level next-state: opposing steps cancel, both ends saturate.
   always_comb begin
      level_d = level_q;
      case ({up_step_s, dn_step_s})
         2'b10: begin
            if (level_q != LVL_MAX) begin
               level_d = level_q + LVL_ONE;
            end else begin
               level_d = level_q;
            end
         end
         2'b01: begin
            if (level_q != LVL_MIN) begin
               level_d = level_q - LVL_ONE;
            end else begin
               level_d = level_q;
            end
         end
         default: level_d = level_q;
      endcase
   end

   // Hysteresis FSM next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (level_q <= LVL_LOW) begin
               state_d = FILLING;
            end else begin
               state_d = IDLE;
            end
         end
         FILLING: begin
            if (level_q >= LVL_HIGH) begin
               state_d = IDLE;
            end else begin
               state_d = FILLING;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Level and FSM state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= LVL_INIT;
         state_q <= IDLE;
      end else begin
         level_q <= level_d;
         state_q <= state_d;
      end
   end

   assign level    = level_q;
   assign empty    = (level_q == LVL_MIN);
   assign full     = (level_q == LVL_MAX);
   assign pump_req = (state_q == FILLING);

`ifdef TANK_ALARM_EN
   logic sat_s;
   logic alarm_q;
   logic alarm_d;

   // A discarded step sets the alarm; a same-cycle clear loses.
   always_comb begin
      sat_s = (up_step_s && !dn_step_s && (level_q == LVL_MAX)) ||
              (dn_step_s && !up_step_s && (level_q == LVL_MIN));
      if (sat_s) begin
         alarm_d = 1'b1;
      end else if (alarm_clr) begin
         alarm_d = 1'b0;
      end else begin
         alarm_d = alarm_q;
      end
   end

   // Sticky alarm register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
      end
   end

   assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_tank_level_counter.sv
// Directed bench for tank_level_counter: a default instance and an
// empty-start, divide-by-one instance driven side by side.
module tb_tank_level_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [3:0] M_DEF_FILL  = 4'b0001;
   localparam logic [3:0] M_DEF_DRAIN = 4'b0010;
   localparam logic [3:0] M_Z_FILL    = 4'b0100;
   localparam logic [3:0] M_Z_DRAIN   = 4'b1000;

   logic       rst_n;
   logic [3:0] pulses;
   logic       def_pump_on;
   logic       z_pump_on;
   logic [7:0] def_level;
   logic [7:0] z_level;
   logic       def_empty, def_full, def_req;
   logic       z_empty, z_full, z_req;
`ifdef TANK_ALARM_EN
   logic       def_clr, z_clr, def_alarm, z_alarm;
`endif

   int total = 0;
   int bad   = 0;
   int req_hi;

   tank_level_counter u_def (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill_pulse  (pulses[0]),
      .drain_pulse (pulses[1]),
      .pump_on     (def_pump_on),
`ifdef TANK_ALARM_EN
      .alarm_clr   (def_clr),
      .alarm       (def_alarm),
`endif
      .level       (def_level),
      .empty       (def_empty),
      .full        (def_full),
      .pump_req    (def_req)
   );

   tank_level_counter #(
      .INIT_LEVEL (0),
      .FILL_DIV   (1),
      .DRAIN_DIV  (1)
   ) u_zero (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill_pulse  (pulses[2]),
      .drain_pulse (pulses[3]),
      .pump_on     (z_pump_on),
`ifdef TANK_ALARM_EN
      .alarm_clr   (z_clr),
      .alarm       (z_alarm),
`endif
      .level       (z_level),
      .empty       (z_empty),
      .full        (z_full),
      .pump_req    (z_req)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Raise pulses and return just after the third rising edge (step not yet applied).
   task automatic raise(input logic [3:0] mask);
      @(negedge clk);
      pulses = mask;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic release_pulse();
      @(negedge clk);
      pulses = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse(input logic [3:0] mask);
      raise(mask);
      @(posedge clk);
      #1;
      release_pulse();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      pulses      = 4'b0000;
      def_pump_on = 1'b0;
      z_pump_on   = 1'b0;
`ifdef TANK_ALARM_EN
      def_clr     = 1'b0;
      z_clr       = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_def_level", int'(def_level), 255);
      check("rst_def_full",  int'(def_full),  1);
      check("rst_def_empty", int'(def_empty), 0);
      check("rst_def_req",   int'(def_req),   0);
      check("rst_z_level",   int'(z_level),   0);
      check("rst_z_empty",   int'(z_empty),   1);
      check("rst_z_req",     int'(z_req),     0);
`ifdef TANK_ALARM_EN
      check("rst_alarm",     int'(def_alarm), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("z_req_after_rst",   int'(z_req),   1);
      check("def_req_after_rst", int'(def_req), 0);

      // Eight drains at divide-by-4: two steps, each 3+1 cycles after the edge.
      def_pump_on = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         raise(M_DEF_DRAIN);
         if (i == 4) check("lat1_pre", int'(def_level), 255);
         if (i == 8) check("lat2_pre", int'(def_level), 254);
         @(posedge clk);
         #1;
         if (i == 4) check("lat1_step", int'(def_level), 254);
         if (i == 8) check("lat2_step", int'(def_level), 253);
         release_pulse();
      end
      check("def_full_253", int'(def_full), 0);

      // Drains with the pump off must neither step nor advance the count.
      def_pump_on = 1'b0;
      for (int i = 0; i < 20; i++) pulse(M_DEF_DRAIN);
      check("pump_off_level", int'(def_level), 253);
      def_pump_on = 1'b1;
      for (int i = 0; i < 3; i++) pulse(M_DEF_DRAIN);
      check("pump_off_cnt_held", int'(def_level), 253);
      pulse(M_DEF_DRAIN);
      check("pump_on_resume", int'(def_level), 252);

      // Draining an empty tank saturates at 0.
      z_pump_on = 1'b1;
      for (int i = 0; i < 4; i++) pulse(M_Z_DRAIN);
      check("z_sat_level", int'(z_level), 0);
      check("z_sat_empty", int'(z_empty), 1);
`ifdef TANK_ALARM_EN
      check("alarm_set", int'(z_alarm), 1);
      @(negedge clk);
      z_clr = 1'b1;
      @(negedge clk);
      z_clr = 1'b0;
      check("alarm_clr", int'(z_alarm), 0);
`endif

      for (int i = 0; i < 5; i++) pulse(M_Z_FILL);
      check("z_fill5", int'(z_level), 5);
      for (int i = 0; i < 3; i++) pulse(M_Z_FILL | M_Z_DRAIN);
      check("z_simultaneous", int'(z_level), 5);
`ifdef TANK_ALARM_EN
      check("alarm_no_sim", int'(z_alarm), 0);
`endif

      // Fill through the band; request drops the cycle after 240.
      for (int i = 0; i < 234; i++) pulse(M_Z_FILL);
      check("z_fill239",     int'(z_level), 239);
      check("z_req_at_239",  int'(z_req),   1);
      raise(M_Z_FILL);
      @(posedge clk);
      #1;
      check("z_level_240",   int'(z_level), 240);
      check("z_req_hold",    int'(z_req),   1);
      @(posedge clk);
      #1;
      check("z_req_drop",    int'(z_req),   0);
      release_pulse();

      req_hi = 0;
      for (int i = 0; i < 223; i++) begin
         pulse(M_Z_DRAIN);
         if (z_req) req_hi++;
      end
      check("z_drain17",     int'(z_level), 17);
      check("z_band_req_lo", req_hi,        0);
      raise(M_Z_DRAIN);
      @(posedge clk);
      #1;
      check("z_level_16",    int'(z_level), 16);
      check("z_req_lo_16",   int'(z_req),   0);
      @(posedge clk);
      #1;
      check("z_req_rise",    int'(z_req),   1);
      release_pulse();

      // Asynchronous reset with the fill prescaler at 3 of 4.
      for (int i = 0; i < 3; i++) pulse(M_DEF_FILL);
      check("pre_rst_level", int'(def_level), 252);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_def", int'(def_level), 255);
      check("async_rst_z",   int'(z_level),   0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) pulse(M_DEF_DRAIN);
      check("post_rst_drain", int'(def_level), 254);
      for (int i = 0; i < 3; i++) pulse(M_DEF_FILL);
      check("post_rst_fill3", int'(def_level), 254);
      pulse(M_DEF_FILL);
      check("post_rst_fill4", int'(def_level), 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
